audio_mixer: RTL and testbench

- Parametrised N-channel audio mixer; successor to the fixed two-source audio output stage.
- Time-multiplexes one channel per sample-enable strobe into a wide accumulator, then saturates to the output width.
- Applies a click-free linear fade when sound enable toggles, and reports sticky clipping.
- Sits between the sound generators (POKEY filter output, analog sound emulation) and the top-level audio port.

---
 rtl/audio_pkg.sv | 22 ++
 rtl/audio_fader.sv | 92 +++++++++
 rtl/audio_mixer.sv | 146 ++++++++++++++
 tb/tb_audio_mixer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types, constants and helpers for the audio mixer and its fader.
package audio_pkg;

    // Fade controller state; the encoding is visible on the fade_state port.
    typedef enum logic [1:0] {
        FADE_OFF  = 2'd0,
        FADE_UP   = 2'd1,
        FADE_ON   = 2'd2,
        FADE_DOWN = 2'd3
    } fade_state_t;

    // A per-channel gain_shift of this value silences the channel entirely.
    localparam logic [2:0] GAIN_MUTE = 3'd7;

    // Unsigned saturation: clamp value to the largest number that fits in width bits.
    function automatic logic [63:0] sat_u(input logic [63:0] value, input int unsigned width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value > max_val) ? max_val : value;
    endfunction

endpackage

// File: rtl/audio_fader.sv
// Click-free fade controller: a linear level ramp between 0 and 2^FADE_W,
// stepped once per mixer frame and steered by the master sound enable.
module audio_fader
    import audio_pkg::*;
#(
    parameter int FADE_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_end,
    input  logic              sound_enable,
    output logic [FADE_W:0]   level,
    output fade_state_t       state
);

    localparam int              LVL_W     = FADE_W + 1;
    localparam logic [LVL_W-1:0] LEVEL_MAX = LVL_W'(1) << FADE_W;

    fade_state_t      state_q, state_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] level_inc;
    logic [LVL_W-1:0] level_dec;

    assign level_inc = level_q + LVL_W'(1);
    assign level_dec = level_q - LVL_W'(1);

    // State and level registers; reset puts the output fully faded out.
    // NOTE: reset is asynchronous (in the sensitivity list) and all state uses
    // non-blocking assignment so every flop samples pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FADE_OFF;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    // Next-state logic; only a frame end may move the ramp.
    // NOTE: defaults are assigned first so no path leaves a variable unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (frame_end) begin
            case (state_q)
                FADE_OFF: begin
                    if (sound_enable) begin
                        state_d = FADE_UP;
                        level_d = LVL_W'(1);
                    end
                end
                FADE_UP: begin
                    if (!sound_enable) begin
                        // Reversal: hold the level this frame so the ramp has no jump.
                        state_d = FADE_DOWN;
                    end else begin
                        level_d = level_inc;
                        if (level_inc == LEVEL_MAX) begin
                            state_d = FADE_ON;
                        end
                    end
                end
                FADE_ON: begin
                    if (!sound_enable) begin
                        state_d = FADE_DOWN;
                        level_d = level_dec;
                    end
                end
                FADE_DOWN: begin
                    if (sound_enable) begin
                        state_d = FADE_UP;
                    end else begin
                        level_d = level_dec;
                        if (level_dec == '0) begin
                            state_d = FADE_OFF;
                        end
                    end
                end
                default: begin
                    state_d = FADE_OFF;
                    level_d = '0;
                end
            endcase
        end
    end

    assign level = level_q;
    assign state = state_q;

endmodule

// File: rtl/audio_mixer.sv
// N-channel audio mixer: scans one channel per clk_en strobe into a wide
// accumulator, saturates the frame sum to OUT_W bits, scales it by the fade
// level and flags clipping until software clears it.
module audio_mixer
    import audio_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int IN_W   = 16,
    parameter int OUT_W  = 16,
    parameter int FADE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic [NCH*IN_W-1:0]   ch_in,
    input  logic [NCH*3-1:0]      gain_shift,
    input  logic                  sound_enable,
    input  logic                  clip_clear,
    output logic [OUT_W-1:0]      out,
    output logic                  out_valid,
    output logic                  clip,
    output logic [1:0]            fade_state
);

    localparam int IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;
    // Headroom sized from the wider of input and output so a wide input can never wrap.
    localparam int BASE_W = (IN_W > OUT_W) ? IN_W : OUT_W;
    localparam int ACC_W  = BASE_W + $clog2(NCH) + 1;
    localparam int LVL_W  = FADE_W + 1;
    localparam int PROD_W = OUT_W + LVL_W;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCH - 1);
    localparam logic [ACC_W-1:0] OUT_MAX  = ACC_W'({OUT_W{1'b1}});

    // With one channel the first and last scan slots coincide, so refuse to build.
    generate
        if (NCH < 2 || NCH > 8) begin : g_bad_nch
            $error("audio_mixer: NCH must be in 2..8");
        end
        if (FADE_W < 1) begin : g_bad_fade
            $error("audio_mixer: FADE_W must be at least 1");
        end
    endgenerate

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              clip_q, clip_d;

    logic [IN_W-1:0]   ch_sel;
    logic [2:0]        shift_sel;
    logic [ACC_W-1:0]  term;
    logic [ACC_W-1:0]  sum;
    logic [OUT_W-1:0]  sat;
    logic [PROD_W-1:0] prod;
    logic              frame_end;
    logic              over;
    logic [LVL_W-1:0]  level;
    fade_state_t       fade_st;

    assign frame_end = clk_en && (idx_q == IDX_LAST);

    // Fade ramp advances once per completed frame.
    audio_fader #(
        .FADE_W (FADE_W)
    ) u_fader (
        .clk          (clk),
        .rst          (rst),
        .frame_end    (frame_end),
        .sound_enable (sound_enable),
        .level        (level),
        .state        (fade_st)
    );

    // Select the channel being scanned and apply its attenuation.
    always_comb begin
        ch_sel    = ch_in[int'(idx_q) * IN_W +: IN_W];
        shift_sel = gain_shift[int'(idx_q) * 3 +: 3];
        term      = '0;
        if (shift_sel != GAIN_MUTE) begin
            term = ACC_W'(ch_sel) >> shift_sel;
        end
    end

    // Frame sum, saturation and fade scaling; full level passes sat unchanged.
    always_comb begin
        sum  = acc_q + term;
        sat  = OUT_W'(sat_u(64'(sum), OUT_W));
        prod = PROD_W'(sat) * PROD_W'(level);
        over = (sum > OUT_MAX);
    end

    // Scan, accumulate and publish; everything holds between strobes except clip clear.
    always_comb begin
        idx_d       = idx_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        clip_d      = clip_q;
        if (clip_clear) begin
            clip_d = 1'b0;
        end
        if (clk_en) begin
            if (idx_q == '0) begin
                acc_d = term;
            end else begin
                acc_d = sum;
            end
            if (frame_end) begin
                out_d       = OUT_W'(prod >> FADE_W);
                out_valid_d = 1'b1;
                // A new clip event on the same edge overrides a clear request.
                if (over) begin
                    clip_d = 1'b1;
                end
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Mixer state registers; reset abandons any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            clip_q      <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            clip_q      <= clip_d;
        end
    end

    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign clip       = clip_q;
    assign fade_state = fade_st;

endmodule

// File: tb/tb_audio_mixer.sv
// Scoreboard bench for audio_mixer: stimulus feeds a behavioural model that
// queues the expected frame result; a monitor compares on every out_valid.
module tb_audio_mixer;

    localparam int NCH    = 4;
    localparam int IN_W   = 16;
    localparam int OUT_W  = 16;
    localparam int FADE_W = 2;
    localparam int MAXL   = 1 << FADE_W;
    localparam longint OMAX = (longint'(1) << OUT_W) - 1;

    logic                clk;
    logic                rst;
    logic                clk_en;
    logic [NCH*IN_W-1:0] ch_in;
    logic [NCH*3-1:0]    gain_shift;
    logic                sound_enable;
    logic                clip_clear;
    logic [OUT_W-1:0]    out;
    logic                out_valid;
    logic                clip;
    logic [1:0]          fade_state;

    audio_mixer #(
        .NCH    (NCH),
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .FADE_W (FADE_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .ch_in        (ch_in),
        .gain_shift   (gain_shift),
        .sound_enable (sound_enable),
        .clip_clear   (clip_clear),
        .out          (out),
        .out_valid    (out_valid),
        .clip         (clip),
        .fade_state   (fade_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint out;
        int     clip;
        int     fs;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Stimulus values as plain integers; packed onto the ports by drive_inputs.
    int ch [NCH];
    int gs [NCH];

    // Reference model: running frame sum, fade level/direction, sticky clip.
    int     m_idx;
    longint m_acc;
    int     m_lvl;
    int     m_dir;
    int     m_clip;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NCH; i++) begin
            ch_in[i*IN_W +: IN_W] = ch[i][IN_W-1:0];
            gain_shift[i*3 +: 3]  = gs[i][2:0];
        end
    endtask

    task automatic set_all(input int a, input int b, input int c, input int d);
        ch[0] = a; ch[1] = b; ch[2] = c; ch[3] = d;
        drive_inputs();
    endtask

    task automatic model_reset();
        m_idx = 0; m_acc = 0; m_lvl = 0; m_dir = 0; m_clip = 0;
    endtask

    // Linear ramp toward the enable's target; a direction change mid-ramp costs one held frame.
    function automatic void fade_step(input bit en);
        int want;
        bit mid;
        want = en ? 1 : -1;
        mid  = (m_lvl > 0) && (m_lvl < MAXL);
        if (mid && want != m_dir) begin
            m_dir = want;
        end else begin
            m_dir = want;
            m_lvl = m_lvl + want;
            if (m_lvl < 0)    m_lvl = 0;
            if (m_lvl > MAXL) m_lvl = MAXL;
        end
    endfunction

    function automatic int fade_code();
        if (m_lvl == 0)    return 0;
        if (m_lvl == MAXL) return 2;
        return (m_dir > 0) ? 1 : 3;
    endfunction

    function automatic longint term_of(input int i);
        if (gs[i] == 7) return 0;
        return longint'(ch[i]) >> gs[i];
    endfunction

    function automatic void model_step(input bit clr);
        exp_t   e;
        longint sat_v;
        m_acc = (m_idx == 0) ? term_of(m_idx) : m_acc + term_of(m_idx);
        if (clr) m_clip = 0;
        if (m_idx == NCH - 1) begin
            sat_v = (m_acc > OMAX) ? OMAX : m_acc;
            e.out = (sat_v * m_lvl) / MAXL;
            if (m_acc > OMAX) m_clip = 1;
            fade_step(sound_enable);
            e.clip = m_clip;
            e.fs   = fade_code();
            sb_q.push_back(e);
            m_idx = 0;
        end else begin
            m_idx++;
        end
    endfunction

    // One strobe, entered and left on a falling edge.
    task automatic strobe(input bit clr = 1'b0);
        clk_en     = 1'b1;
        clip_clear = clr;
        model_step(clr);
        @(negedge clk);
        clk_en     = 1'b0;
        clip_clear = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int f = 0; f < n * NCH; f++) strobe();
    endtask

    // Monitor: every out_valid must match the oldest queued frame result.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", out_valid, 0);
            end else begin
                e = sb_q.pop_front();
                check("out", out, e.out);
                check("clip", clip, e.clip);
                check("fade_state", fade_state, e.fs);
            end
        end
    end

    initial begin
        logic [OUT_W-1:0] held;
        rst = 1'b1; clk_en = 1'b0; clip_clear = 1'b0; sound_enable = 1'b1;
        ch_in = '0; gain_shift = '0;
        for (int i = 0; i < NCH; i++) begin ch[i] = 0; gs[i] = 0; end
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_out", out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_clip", clip, 0);
        check("rst_fade_state", fade_state, 0);
        rst = 1'b0;
        @(negedge clk);

        // Ramp-up: 0, 2500, 5000, 7500, 10000, 10000.
        set_all(1000, 2000, 3000, 4000);
        frames(6);

        // Full scale: saturation and clip; clear on frame end loses to the set.
        set_all(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        frames(2);
        for (int k = 0; k < NCH - 1; k++) strobe();
        strobe(1'b1);
        clip_clear = 1'b1;
        m_clip     = 0;
        @(negedge clk);
        clip_clear = 1'b0;
        check("clip_cleared", clip, m_clip);

        // Per-channel attenuation with channel 0 muted: 14000 at full level.
        gs[0] = 7; gs[1] = 1; gs[2] = 2; gs[3] = 0;
        set_all(8000, 8000, 8000, 8000);
        frames(2);

        // Fade down two frames, then reverse mid-ramp and come back up.
        sound_enable = 1'b0;
        frames(2);
        sound_enable = 1'b1;
        frames(4);

        // Asynchronous reset at idx 2 clears everything immediately.
        strobe(); strobe();
        rst = 1'b1;
        #1;
        check("mid_rst_out", out, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_clip", clip, 0);
        check("mid_rst_fade", fade_state, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        frames(3);

        // Stall mid-frame: ch_in wiggles but nothing moves without clk_en.
        strobe();
        held = out;
        for (int k = 0; k < 20; k++) begin
            ch_in = {$urandom, $urandom};
            @(negedge clk);
            check("stall_out", out, held);
            check("stall_valid", out_valid, 0);
        end
        drive_inputs();
        for (int k = 0; k < NCH - 1; k++) strobe();

        // Randomised frames: samples, gains, enable, clears and idle gaps.
        for (int s = 0; s < 40 * NCH; s++) begin
            for (int i = 0; i < NCH; i++) begin
                ch[i] = int'($urandom_range(0, 65535));
                gs[i] = int'($urandom_range(0, 7));
            end
            drive_inputs();
            if ($urandom_range(0, 5) == 0) sound_enable = ~sound_enable;
            strobe($urandom_range(0, 7) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
